// File: rtl/bus_dev_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module  : bus_dev_fifo_bank
// Brief   : Bank of per-channel device-side FIFOs between devices and the bus
//           arbiter. Each channel has a TX FIFO (device -> bus) and an RX FIFO
//           (bus -> device), both show-ahead. The bank also reports TX
//           occupancy and keeps sticky overflow/underflow flags.
// Revision: 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// bus_dev_fifo : single show-ahead FIFO with occupancy count and sticky
// overflow/underflow flags. Used twice per channel by the bank below.
// ----------------------------------------------------------------------------
module bus_dev_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  input  logic             err_clr,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW-1:0] c_ptr_one = PTRW'(1);
  localparam logic [CW-1:0]   c_cnt_one = CW'(1);
  localparam logic [CW-1:0]   c_cnt_max = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wptr;
  logic [PTRW-1:0]  r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_udf;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;
  logic w_set_ovf;
  logic w_set_udf;

  // A read only takes effect on a non-empty FIFO; a write into a full FIFO is
  // accepted only when a read frees a slot on the same edge.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cnt_max);
  assign w_do_rd   = rd & ~w_empty;
  assign w_do_wr   = wr & (~w_full | w_do_rd);
  assign w_set_ovf = wr & w_full & ~rd;
  assign w_set_udf = rd & w_empty;

  // Pointers and occupancy; pointers are log2(DEPTH) wide and wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + c_ptr_one;
      if (w_do_rd) r_rptr <= r_rptr + c_ptr_one;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wdata;
  end

  // Sticky error flags: a new error on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_set_ovf)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_set_udf)    r_udf <= 1'b1;
      else if (err_clr) r_udf <= 1'b0;
    end
  end

  assign head  = w_empty ? '0 : r_mem[r_rptr];
  assign count = r_count;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// ----------------------------------------------------------------------------
// bus_dev_fifo_bank : DRVRS independent channels, each with TX and RX FIFOs.
// ----------------------------------------------------------------------------
module bus_dev_fifo_bank #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         wr_en,
  input  logic [DRVRS*PCKG_SZ-1:0] wr_data,
  output logic [DRVRS-1:0]         tx_full,
  output logic [DRVRS*CW-1:0]      tx_count,
  input  logic [DRVRS-1:0]         rd_en,
  output logic [DRVRS*PCKG_SZ-1:0] rd_data,
  output logic [DRVRS-1:0]         rx_empty,
  output logic [DRVRS-1:0]         pndng,
  output logic [DRVRS*PCKG_SZ-1:0] D_pop,
  input  logic [DRVRS-1:0]         pop,
  input  logic [DRVRS-1:0]         push,
  input  logic [DRVRS*PCKG_SZ-1:0] D_push,
  input  logic                     err_clr,
  output logic [DRVRS-1:0]         tx_ovf,
  output logic [DRVRS-1:0]         rx_ovf,
  output logic [DRVRS-1:0]         pop_udf
);

  localparam logic [CW-1:0] c_cnt_max = CW'(DEPTH);

  for (genvar g = 0; g < DRVRS; g++) begin : g_chan
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic          w_tx_udf;
    logic          w_rx_udf;

    bus_dev_fifo #(
      .WIDTH (PCKG_SZ),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_en[g]),
      .wdata   (wr_data[g*PCKG_SZ +: PCKG_SZ]),
      .rd      (pop[g]),
      .err_clr (err_clr),
      .head    (D_pop[g*PCKG_SZ +: PCKG_SZ]),
      .count   (w_tx_count),
      .ovf     (tx_ovf[g]),
      .udf     (w_tx_udf)
    );

    bus_dev_fifo #(
      .WIDTH (PCKG_SZ),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .wr      (push[g]),
      .wdata   (D_push[g*PCKG_SZ +: PCKG_SZ]),
      .rd      (rd_en[g]),
      .err_clr (err_clr),
      .head    (rd_data[g*PCKG_SZ +: PCKG_SZ]),
      .count   (w_rx_count),
      .ovf     (rx_ovf[g]),
      .udf     (w_rx_udf)
    );

    // Status derived purely from registered counts, so no strobe reaches an output.
    assign tx_count[g*CW +: CW] = w_tx_count;
    assign tx_full[g]           = (w_tx_count == c_cnt_max);
    assign pndng[g]             = (w_tx_count != '0);
    assign rx_empty[g]          = (w_rx_count == '0);
    assign pop_udf[g]           = w_tx_udf | w_rx_udf;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_dev_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_dev_fifo_bank
// Brief   : Self-checking bench for bus_dev_fifo_bank: a vector table for the
//           single-step behaviour plus scoreboard-driven TX sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_dev_fifo_bank;

  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 16;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic [DRVRS-1:0]         wr_en;
  logic [DRVRS*PCKG_SZ-1:0] wr_data;
  logic [DRVRS-1:0]         tx_full;
  logic [DRVRS*CW-1:0]      tx_count;
  logic [DRVRS-1:0]         rd_en;
  logic [DRVRS*PCKG_SZ-1:0] rd_data;
  logic [DRVRS-1:0]         rx_empty;
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [DRVRS*PCKG_SZ-1:0] D_push;
  logic                     err_clr;
  logic [DRVRS-1:0]         tx_ovf;
  logic [DRVRS-1:0]         rx_ovf;
  logic [DRVRS-1:0]         pop_udf;

  bus_dev_fifo_bank #(
    .DRVRS   (DRVRS),
    .PCKG_SZ (PCKG_SZ),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_full  (tx_full),
    .tx_count (tx_count),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .err_clr  (err_clr),
    .tx_ovf   (tx_ovf),
    .rx_ovf   (rx_ovf),
    .pop_udf  (pop_udf)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    int          ch;
    logic        wr;
    logic [15:0] wd;
    logic        pp;
    logic        ps;
    logic [15:0] dp;
    logic        rd;
    logic        clr;
    logic        e_pndng;
    logic [15:0] e_dpop;
    int          e_cnt;
    logic        e_rxe;
    logic [15:0] e_rd;
    logic        e_udf;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    wr_en = '0; wr_data = '0; rd_en = '0; pop = '0;
    push = '0; D_push = '0; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b0;
    step();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One TX operation on a channel, checked against the bench's queue model.
  task automatic tx_op(input int ch, input logic w, input logic [15:0] d, input logic p);
    logic rd_ok, wr_ok;
    chk("tx_head", 32'(D_pop[ch*PCKG_SZ +: PCKG_SZ]), (model.size() > 0) ? 32'(model[0]) : 32'h0);
    clear_in();
    wr_en[ch] = w;
    wr_data[ch*PCKG_SZ +: PCKG_SZ] = d;
    pop[ch] = p;
    step();
    rd_ok = p && (model.size() > 0);
    wr_ok = w && ((model.size() < DEPTH) || rd_ok);
    if (rd_ok) void'(model.pop_front());
    if (wr_ok) model.push_back(d);
    chk("tx_count", 32'(tx_count[ch*CW +: CW]), 32'(model.size()));
    clear_in();
  endtask

  initial begin
    // name, ch, wr, wd, pop, push, dpush, rd, clr, e_pndng, e_dpop, e_cnt, e_rxe, e_rd, e_udf
    vecs.push_back('{"wr1",     0, 1, 16'hA001, 0, 0, 16'h0,    0, 0, 1, 16'hA001, 1, 1, 16'h0,    0});
    vecs.push_back('{"wr2",     0, 1, 16'hA002, 0, 0, 16'h0,    0, 0, 1, 16'hA001, 2, 1, 16'h0,    0});
    vecs.push_back('{"pop1",    0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 1, 16'hA002, 1, 1, 16'h0,    0});
    vecs.push_back('{"pop2",    0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 0, 16'h0,    0, 1, 16'h0,    0});
    vecs.push_back('{"pop_mt",  0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 0, 16'h0,    0, 1, 16'h0,    1});
    vecs.push_back('{"clr0",    0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0,    0, 1, 16'h0,    0});
    vecs.push_back('{"push3",   3, 0, 16'h0,    0, 1, 16'hBEEF, 0, 0, 0, 16'h0,    0, 0, 16'hBEEF, 0});
    vecs.push_back('{"rd3",     3, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 16'h0,    0});
    vecs.push_back('{"rd3_mt",  3, 0, 16'h0,    0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 16'h0,    1});
    vecs.push_back('{"clr3",    3, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0,    0, 1, 16'h0,    0});
    vecs.push_back('{"set_clr", 3, 0, 16'h0,    0, 0, 16'h0,    1, 1, 0, 16'h0,    0, 1, 16'h0,    1});
    vecs.push_back('{"clr3b",   3, 0, 16'h0,    0, 0, 16'h0,    0, 1, 0, 16'h0,    0, 1, 16'h0,    0});
    vecs.push_back('{"wrpop_mt",1, 1, 16'h1234, 1, 0, 16'h0,    0, 0, 1, 16'h1234, 1, 1, 16'h0,    1});
    vecs.push_back('{"clr1",    1, 0, 16'h0,    0, 0, 16'h0,    0, 1, 1, 16'h1234, 1, 1, 16'h0,    0});

    // Reset state
    clear_in();
    reset = 1'b0;
    #12;
    chk("rst_pndng",    32'(pndng),    32'h0);
    chk("rst_tx_full",  32'(tx_full),  32'h0);
    chk("rst_tx_count", 32'(tx_count), 32'h0);
    chk("rst_rx_empty", 32'(rx_empty), 32'hF);
    chk("rst_flags",    32'({tx_ovf, rx_ovf, pop_udf}), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single-step vectors
    foreach (vecs[k]) begin
      int c;
      c = vecs[k].ch;
      clear_in();
      wr_en[c] = vecs[k].wr;
      wr_data[c*PCKG_SZ +: PCKG_SZ] = vecs[k].wd;
      pop[c] = vecs[k].pp;
      push[c] = vecs[k].ps;
      D_push[c*PCKG_SZ +: PCKG_SZ] = vecs[k].dp;
      rd_en[c] = vecs[k].rd;
      err_clr = vecs[k].clr;
      step();
      chk({vecs[k].name, "_pndng"},   32'(pndng[c]), 32'(vecs[k].e_pndng));
      chk({vecs[k].name, "_dpop"},    32'(D_pop[c*PCKG_SZ +: PCKG_SZ]), 32'(vecs[k].e_dpop));
      chk({vecs[k].name, "_cnt"},     32'(tx_count[c*CW +: CW]), 32'(vecs[k].e_cnt));
      chk({vecs[k].name, "_rxempty"}, 32'(rx_empty[c]), 32'(vecs[k].e_rxe));
      chk({vecs[k].name, "_rddata"},  32'(rd_data[c*PCKG_SZ +: PCKG_SZ]), 32'(vecs[k].e_rd));
      chk({vecs[k].name, "_udf"},     32'(pop_udf[c]), 32'(vecs[k].e_udf));
    end
    clear_in();

    // Fill ch2, overflow, then drain in order
    model.delete();
    for (int i = 0; i < DEPTH; i++) tx_op(2, 1'b1, 16'h0200 + 16'(i), 1'b0);
    chk("ch2_full_pre_ovf", 32'(tx_ovf[2]), 32'h0);
    tx_op(2, 1'b1, 16'h0208, 1'b0);
    chk("ch2_full", 32'(tx_full[2]), 32'h1);
    chk("ch2_ovf",  32'(tx_ovf[2]),  32'h1);
    for (int i = 0; i < DEPTH; i++) tx_op(2, 1'b0, 16'h0, 1'b1);
    chk("ch2_empty_pndng", 32'(pndng[2]), 32'h0);
    chk("ch2_empty_dpop",  32'(D_pop[2*PCKG_SZ +: PCKG_SZ]), 32'h0);

    // ch1 full with simultaneous write+pop, across pointer wrap
    do_reset();
    model.delete();
    for (int i = 0; i < DEPTH; i++) tx_op(1, 1'b1, 16'h1000 + 16'(i), 1'b0);
    tx_op(1, 1'b1, 16'h1111, 1'b1);
    chk("ch1_wrpop_full", 32'(tx_full[1]), 32'h1);
    for (int i = 0; i < 19; i++) tx_op(1, 1'b1, 16'h1200 + 16'(i), 1'b1);
    chk("ch1_no_ovf", 32'(tx_ovf[1]), 32'h0);
    for (int i = 0; i < DEPTH; i++) tx_op(1, 1'b0, 16'h0, 1'b1);
    chk("ch1_drained", 32'(pndng[1]), 32'h0);

    // All channels concurrently, no cross-talk
    do_reset();
    for (int c = 0; c < DRVRS; c++) begin
      wr_en[c] = 1'b1;
      push[c]  = 1'b1;
      wr_data[c*PCKG_SZ +: PCKG_SZ] = 16'hC000 | 16'(c << 4);
      D_push[c*PCKG_SZ +: PCKG_SZ]  = 16'hC001 | 16'(c << 4);
    end
    step();
    clear_in();
    for (int c = 0; c < DRVRS; c++) begin
      chk("all_pndng", 32'(pndng[c]), 32'h1);
      chk("all_dpop",  32'(D_pop[c*PCKG_SZ +: PCKG_SZ]), 32'(16'hC000 | 16'(c << 4)));
      chk("all_rdata", 32'(rd_data[c*PCKG_SZ +: PCKG_SZ]), 32'(16'hC001 | 16'(c << 4)));
      chk("all_rxe",   32'(rx_empty[c]), 32'h0);
      chk("all_cnt",   32'(tx_count[c*CW +: CW]), 32'h1);
    end

    // Asynchronous reset mid-cycle with entries held
    do_reset();
    model.delete();
    for (int i = 0; i < 5; i++) tx_op(0, 1'b1, 16'h0500 + 16'(i), 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_pndng", 32'(pndng[0]), 32'h0);
    chk("arst_cnt",   32'(tx_count[0 +: CW]), 32'h0);
    chk("arst_dpop",  32'(D_pop[0 +: PCKG_SZ]), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model.delete();
    tx_op(0, 1'b1, 16'h5555, 1'b0);
    tx_op(0, 1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_dev_fifo_bank.md
Name: bus_dev_fifo_bank

Overview:
Synthesisable bank of DRVRS device-side interface FIFOs that sits between the devices and the bus arbiter (bs_gnrtr_n_rbtr).
- Each channel has a TX FIFO (device→bus) that drives pndng/D_pop and consumes pop.
- Each channel has an RX FIFO (bus→device) that captures push/D_push.
- Generalises the per-driver queue to parametrised width, depth and channel count.
- Adds occupancy reporting and sticky overflow/underflow error flags.

Parameters:
DRVRS, 4, number of device channels (≥1)
PCKG_SZ, 16, packet width in bits (≥2)
DEPTH, 8, entries per FIFO; power of two, ≥2
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  DRVRS  device write strobe into TX FIFO, per channel
wr_data  in  DRVRS*PCKG_SZ  TX write data, channel i at [i*PCKG_SZ +: PCKG_SZ]
tx_full  out  DRVRS  TX FIFO full
tx_count  out  DRVRS*CW  TX occupancy, channel i at [i*CW +: CW]
rd_en  in  DRVRS  device read strobe from RX FIFO
rd_data  out  DRVRS*PCKG_SZ  RX head (show-ahead)
rx_empty  out  DRVRS  RX FIFO empty
pndng  out  DRVRS  TX FIFO non-empty, to arbiter
D_pop  out  DRVRS*PCKG_SZ  TX head (show-ahead), to arbiter
pop  in  DRVRS  arbiter consumed TX head
push  in  DRVRS  arbiter delivers packet to RX FIFO
D_push  in  DRVRS*PCKG_SZ  delivered packet
err_clr  in  1  synchronous clear of all sticky error flags
tx_ovf  out  DRVRS  sticky: TX write dropped while full
rx_ovf  out  DRVRS  sticky: RX push dropped while full
pop_udf  out  DRVRS  sticky: pop or rd_en while the respective FIFO is empty

Behaviour:
- Reset (reset=0, async): read/write pointers and counts → 0; all flags → 0. Outputs: pndng=0, tx_full=0, tx_count=0, rx_empty=1. Contents discarded even mid-operation. Release is synchronous to the next edge.
- Channels are fully independent; no cross-channel state.
- Show-ahead: D_pop/rd_data equal the head entry combinationally from registered pointers. They are forced to 0 when the FIFO is empty.
- Write latency: wr_en at edge t → pndng=1, tx_count=1, D_pop=data valid after edge t (same for push → rx_empty=0).
- Read: pop (or rd_en) at edge t with FIFO non-empty advances the head. The next entry is visible after edge t.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count rules, per FIFO per edge:
  - write only: +1
  - read only: −1
  - both: unchanged, head advances, tail written
- Full boundary:
  - Write while full and no read → dropped; overflow flag set; contents unchanged.
  - Write while full with a simultaneous read → accepted; count stays DEPTH.
- Empty boundary:
  - Read while empty → ignored; pop_udf set.
  - Simultaneous write and read while empty → read ignored with pop_udf set; write accepted; count=1.
- tx_full = (tx_count==DEPTH); pndng = (tx_count!=0).
- Sticky flags:
  - Set on the offending edge.
  - Cleared by err_clr=1 at an edge.
  - If set and clear coincide, set wins.
- No combinational path from pop/push/wr_en/rd_en to any output.

Test Plan:
1. Reset, then wr_en ch0 with 0xA001, 0xA002 on consecutive edges → pndng[0]=1 after the first edge; D_pop ch0=0xA001; tx_count ch0=2. Pulse pop → D_pop=0xA002, count=1. Second pop → pndng=0, D_pop=0.
2. Fill ch2 TX with 8 writes (0x0200..0x0207), then a 9th write 0x0208 → tx_full[2]=1, tx_ovf[2]=1. Drain 8 pops → data sequence 0x0200..0x0207, 0x0208 never appears.
3. ch1 TX full: write 0x1111 with pop in the same cycle → count stays 8, tx_ovf[1]=0, 0x1111 emerges last. Repeat for 20 cycles to exercise pointer wrap, checking FIFO order against a scoreboard.
4. push ch3 D_push=0xBEEF → rx_empty[3]=0, rd_data=0xBEEF. rd_en → rx_empty=1. Extra rd_en → pop_udf[3]=1. err_clr → pop_udf[3]=0. Set and clear in the same cycle → flag remains 1.
5. All 4 channels write and push concurrently with distinct data 0xC0i0 → each channel's pndng/D_pop/rd_data shows only its own data; no cross-talk.
6. Assert reset low asynchronously (mid-cycle) with ch0 TX holding 5 entries → pndng[0]=0, tx_count=0 immediately. After release, a write of 0x5555 is the first D_pop.
